// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode definitions: scalar typedefs, fetch FSM states, op field and opcode constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_unit_pkg;

    typedef logic        u1;
    typedef logic [5:0]  u6;
    typedef logic [31:0] u32;

    // Fetch sequencing: one request outstanding, one instruction held for decode.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

    // Location of the major opcode inside an instruction word.
    localparam int OP_FIELD_HI = 31;
    localparam int OP_FIELD_LO = 26;

    localparam u32 RESET_PC_DEFAULT = 32'h0000_0000;

    // Next-PC select codes driven into fetch_unit_pc_next.
    localparam logic [1:0] PC_SEL_HOLD = 2'd0;
    localparam logic [1:0] PC_SEL_INC  = 2'd1;
    localparam logic [1:0] PC_SEL_BR   = 2'd2;
    localparam logic [1:0] PC_SEL_J    = 2'd3;

    // Major opcodes recognised by the downstream decoder.
    localparam u6 OP_RTYPE = 6'h00;
    localparam u6 OP_J     = 6'h02;
    localparam u6 OP_JAL   = 6'h03;
    localparam u6 OP_BEQ   = 6'h04;
    localparam u6 OP_BNE   = 6'h05;
    localparam u6 OP_ADDI  = 6'h08;
    localparam u6 OP_LW    = 6'h23;
    localparam u6 OP_SW    = 6'h2B;

    // Redirect targets are word addresses; the two low bits are discarded.
    function automatic u32 align_word(input u32 addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Next-PC select: hold, sequential +4 (wrapping), aligned branch target or aligned jump target.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the selected value is loaded.
module fetch_unit_pc_next
    import fetch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  sel,
    input  logic [31:0] br_target,
    input  logic [31:0] j_target,
    output logic [31:0] pc_nxt,
    output logic [31:0] pc_plus4
);

    // Sequential successor; wraps modulo 2^32 by construction.
    assign pc_plus4 = pc + 32'd4;

    // Choose the value the PC register takes on the next edge.
    always_comb begin
        pc_nxt = pc;
        case (sel)
            PC_SEL_HOLD: pc_nxt = pc;
            PC_SEL_INC:  pc_nxt = pc_plus4;
            PC_SEL_BR:   pc_nxt = align_word(br_target);
            PC_SEL_J:    pc_nxt = align_word(j_target);
            default:     pc_nxt = pc;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues one imem request at a time, presents the word to decode.
// Latency: instr_valid two cycles after the accepted request when memory answers one cycle later.
// Backpressure: holds instr/op/pc while instr_ready is low; redirects discard held or in-flight words.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_br,
    input  logic [31:0] br_target,
    input  logic        redirect_j,
    input  logic [31:0] j_target,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    fetch_state_e state;
    logic         drop;      // in-flight response is stale and must be discarded
    logic         rst_q;     // first cycle after reset, when a leftover rvalid is tolerated
    logic         redirect;
    logic         fire;
    logic [1:0]   pc_sel;
    logic [31:0]  pc_nxt;

    assign redirect  = redirect_br | redirect_j;
    assign fire      = imem_req & imem_ready;
    assign imem_addr = pc;
    assign op        = instr_valid ? instr[OP_FIELD_HI:OP_FIELD_LO] : 6'b0;

    // PC source: redirects apply in every active state, jump over branch; +4 only when decode consumes.
    always_comb begin
        pc_sel = PC_SEL_HOLD;
        if (state != IDLE) begin
            if (redirect_j) begin
                pc_sel = PC_SEL_J;
            end else if (redirect_br) begin
                pc_sel = PC_SEL_BR;
            end else if (state == HOLD && instr_ready) begin
                pc_sel = PC_SEL_INC;
            end
        end
    end

    fetch_unit_pc_next u_pc_next (
        .pc        (pc),
        .sel       (pc_sel),
        .br_target (br_target),
        .j_target  (j_target),
        .pc_nxt    (pc_nxt),
        .pc_plus4  (pc_plus4)
    );

    // Fetch FSM with registered request/valid outputs; all fetch state lives here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            drop        <= 1'b0;
            instr       <= 32'h0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            pc <= pc_nxt;
            case (state)
                IDLE: begin
                    state    <= REQ;
                    imem_req <= 1'b1;
                end
                REQ: begin
                    // A redirect coinciding with acceptance makes that request stale.
                    if (fire) begin
                        state    <= WAIT;
                        imem_req <= 1'b0;
                        drop     <= redirect;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (drop || redirect) begin
                            drop     <= 1'b0;
                            state    <= REQ;
                            imem_req <= 1'b1;
                        end else begin
                            instr       <= imem_rdata;
                            state       <= HOLD;
                            instr_valid <= 1'b1;
                        end
                    end else if (redirect) begin
                        drop <= 1'b1;
                    end
                end
                HOLD: begin
                    // A redirect wins over consumption: the held word is simply abandoned.
                    if (redirect || instr_ready) begin
                        state       <= REQ;
                        imem_req    <= 1'b1;
                        instr_valid <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

    // Remember that the previous cycle was in reset, so a response from before reset is not flagged.
    always_ff @(posedge clk) begin
        rst_q <= reset;
    end

    a_no_rvalid_without_request: assert property (@(posedge clk) disable iff (reset)
        !(imem_rvalid && !rst_q && (state == IDLE || state == REQ)));

    a_instr_valid_known: assert property (@(posedge clk) disable iff (reset)
        !$isunknown(instr_valid));

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_br;
    logic [31:0] br_target;
    logic        redirect_j;
    logic [31:0] j_target;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RPC)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect_br (redirect_br),
        .br_target   (br_target),
        .redirect_j  (redirect_j),
        .j_target    (j_target),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .op          (op),
        .pc          (pc),
        .pc_plus4    (pc_plus4)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Transaction-level model of the fetch stage.
    bit          m_idle;        // first cycle after reset: nothing happens
    logic [31:0] m_next_pc;     // address the next request must carry
    bit          m_out;         // a request has been accepted and not answered
    logic [31:0] m_out_addr;
    bit          m_stale;       // outstanding answer will be thrown away
    bit          m_held;        // an instruction is on offer to decode
    logic [31:0] m_held_addr;
    logic [31:0] m_held_word;

    // Memory model.
    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;
    int          dly_min = 1;
    int          dly_max = 1;
    bit          mem_lw = 1'b1;
    bit          force_rv = 1'b0;

    logic [31:0] fire_q[$];
    int          valid_cnt;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_lw) return 32'h8C00_0000;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic model_reset();
        m_idle    = 1'b1;
        m_next_pc = RPC;
        m_out     = 1'b0;
        m_stale   = 1'b0;
        m_held    = 1'b0;
        mem_busy  = 1'b0;
    endtask

    task automatic check_outputs();
        logic [31:0] exp_pc;
        exp_pc = m_held ? m_held_addr : m_next_pc;
        check("instr_valid", 32'(instr_valid), 32'(m_held));
        check("imem_req", 32'(imem_req), 32'(!m_idle && !m_out && !m_held));
        check("pc", pc, exp_pc);
        check("imem_addr", imem_addr, exp_pc);
        check("pc_plus4", pc_plus4, exp_pc + 32'd4);
        if (m_held) begin
            check("instr", instr, m_held_word);
            check("op", 32'(op), 32'(m_held_word[31:26]));
        end else begin
            check("op_gated", 32'(op), 32'd0);
        end
        if (instr_valid) valid_cnt++;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        redirect_br = 1'b0;
        redirect_j  = 1'b0;
        br_target   = 32'h0;
        j_target    = 32'h0;
        instr_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_outputs();
        check("rst_instr", instr, 32'h0);
        check("rst_pc", pc, RPC);
        reset = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare.
    task automatic step(input bit ready_i, input bit ir_i, input bit br_i, input logic [31:0] bt_i,
                        input bit j_i, input logic [31:0] jt_i);
        bit          rv;
        bit          fire_dut;
        bit          redir;
        bit          was_held;
        bit          was_req;
        logic [31:0] rd;
        logic [31:0] tgt;

        rv = force_rv || (mem_busy && mem_cnt == 1);
        rd = (rv && !force_rv) ? mem_word(mem_addr) : $urandom();
        force_rv = 1'b0;

        imem_ready  = ready_i;
        imem_rvalid = rv;
        imem_rdata  = rd;
        instr_ready = ir_i;
        redirect_br = br_i;
        br_target   = bt_i;
        redirect_j  = j_i;
        j_target    = jt_i;

        fire_dut = imem_req && ready_i;
        if (fire_dut) fire_q.push_back(imem_addr);

        redir = br_i || j_i;
        tgt   = (j_i ? jt_i : bt_i) & 32'hFFFF_FFFC;
        if (m_idle) begin
            m_idle = 1'b0;
        end else begin
            was_held = m_held;
            was_req  = !m_out && !m_held;
            if (m_out && rv) begin
                m_out = 1'b0;
                if (!(m_stale || redir)) begin
                    m_held      = 1'b1;
                    m_held_addr = m_out_addr;
                    m_held_word = rd;
                end
            end else if (m_out && redir) begin
                m_stale = 1'b1;
            end
            if (was_req && ready_i) begin
                m_out      = 1'b1;
                m_out_addr = m_next_pc;
                m_stale    = redir;
            end
            if (was_held && (redir || ir_i)) begin
                m_held = 1'b0;
                if (!redir) m_next_pc = m_next_pc + 32'd4;
            end
            if (redir) m_next_pc = tgt;
        end

        if (mem_busy) begin
            if (mem_cnt == 1) mem_busy = 1'b0;
            else mem_cnt--;
        end
        if (fire_dut) begin
            mem_busy = 1'b1;
            mem_addr = imem_addr;
            mem_cnt  = $urandom_range(dly_max, dly_min);
        end

        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        logic [31:0] exp_fetch[4];
        exp_fetch[0] = 32'hFFFF_FFFC;
        exp_fetch[1] = 32'h0000_0000;
        exp_fetch[2] = 32'h0000_0004;
        exp_fetch[3] = 32'h0000_0008;

        do_reset();

        // Streaming LW fetches from the top of the address space, across the wrap.
        fire_q.delete();
        valid_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step(1, 1, 0, 32'h0, 0, 32'h0);
            if (i == 2) begin
                check("wrap_pc_plus4", pc_plus4, 32'h0);
                check("lw_op", 32'(op), 32'h23);
            end
            if (i == 3) check("wrap_next_req", imem_addr, 32'h0);
        end
        check("t1_fetch_cnt", fire_q.size(), 32'd4);
        for (int k = 0; k < 4 && k < fire_q.size(); k++) check("t1_fetch_addr", fire_q[k], exp_fetch[k]);
        check("t1_valid_cnt", valid_cnt, 32'd4);
        check("t1_pc", pc, 32'h8);

        // Decode stalls for five cycles at pc 0x8.
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 32'h0, 0, 32'h0);
            check("t2_pc_stable", pc, 32'h8);
            check("t2_no_req", 32'(imem_req), 32'd0);
            check("t2_valid", 32'(instr_valid), 32'd1);
        end
        step(1, 1, 0, 32'h0, 0, 32'h0);
        check("t2_next_addr", imem_addr, 32'hC);
        check("t2_next_req", 32'(imem_req), 32'd1);

        // Branch while waiting: the returning word must be discarded.
        dly_min = 2;
        dly_max = 2;
        step(1, 0, 0, 32'h0, 0, 32'h0);
        step(1, 0, 1, 32'h40, 0, 32'h0);
        check("t3_wait_valid", 32'(instr_valid), 32'd0);
        step(1, 0, 0, 32'h0, 0, 32'h0);
        check("t3_discard_valid", 32'(instr_valid), 32'd0);
        check("t3_req", 32'(imem_req), 32'd1);
        check("t3_addr", imem_addr, 32'h40);

        // Jump and branch together in HOLD with decode ready: jump wins, held word dropped.
        dly_min = 1;
        dly_max = 1;
        step(1, 0, 0, 32'h0, 0, 32'h0);
        step(1, 0, 0, 32'h0, 0, 32'h0);
        check("t4_hold_pc", pc, 32'h40);
        step(1, 1, 1, 32'h200, 1, 32'h100);
        check("t4_valid", 32'(instr_valid), 32'd0);
        check("t4_addr", imem_addr, 32'h100);

        // Memory stalls in REQ, misaligned redirect in the second stalled cycle.
        step(0, 0, 0, 32'h0, 0, 32'h0);
        check("t5_addr0", imem_addr, 32'h100);
        step(0, 0, 1, 32'h83, 0, 32'h0);
        check("t5_addr1", imem_addr, 32'h80);
        step(0, 0, 0, 32'h0, 0, 32'h0);
        check("t5_addr2", imem_addr, 32'h80);
        step(1, 0, 0, 32'h0, 0, 32'h0);
        check("t5_fire_addr", fire_q[$], 32'h80);
        step(1, 0, 0, 32'h0, 0, 32'h0);
        check("t5_valid", 32'(instr_valid), 32'd1);
        check("t5_pc", pc, 32'h80);

        // Reset while a fetch is outstanding, then a leftover response arrives.
        step(1, 1, 0, 32'h0, 0, 32'h0);
        step(1, 0, 0, 32'h0, 0, 32'h0);
        do_reset();
        force_rv = 1'b1;
        step(1, 0, 0, 32'h0, 0, 32'h0);
        check("t6_pc", pc, RPC);
        check("t6_req", 32'(imem_req), 32'd1);
        check("t6_valid", 32'(instr_valid), 32'd0);
        for (int i = 0; i < 6; i++) step(1, 1, 0, 32'h0, 0, 32'h0);

        // Randomised traffic against the model.
        mem_lw  = 1'b0;
        dly_min = 1;
        dly_max = 3;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(99, 0) == 0) begin
                do_reset();
                if ($urandom_range(1, 0) == 1) force_rv = 1'b1;
            end
            step($urandom_range(99, 0) < 75, $urandom_range(99, 0) < 60,
                 $urandom_range(99, 0) < 8, $urandom(),
                 $urandom_range(99, 0) < 5, $urandom());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the main decoder. Owns the PC and issues one instruction-memory request at a time. Captures the returned word and presents it, with its PC and op field, to decode under a valid/ready handshake. Applies branch and jump redirects from the execute/control path and drops any in-flight fetch made stale by a redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
imem_req  output  1  request valid to instruction memory
imem_addr  output  32  word-aligned fetch address (= pc)
imem_ready  input  1  memory accepts request this cycle
imem_rvalid  input  1  read data valid (at most one per accepted request, ≥1 cycle after accept)
imem_rdata  input  32  instruction word
redirect_br  input  1  taken branch; target = br_target
br_target  input  32  branch target
redirect_j  input  1  jump; target = j_target
j_target  input  32  jump target
instr_valid  output  1  instr/pc/op valid to decoder
instr_ready  input  1  decoder consumes this cycle
instr  output  32  held instruction
op  output  6  instr[31:26] when instr_valid, else 6'b0
pc  output  32  address of held/current fetch
pc_plus4  output  32  pc + 4, modulo 2^32

Behaviour:
- Reset values (same cycle reset is sampled high): state=IDLE, pc=RESET_PC, drop=0, imem_req=0, instr=0, instr_valid=0, op=0. Reset mid-operation abandons any in-flight fetch. Any imem_rvalid in the first cycle after reset is ignored.
- Redirect: redirect = redirect_br | redirect_j. The target is j_target when redirect_j is high, otherwise br_target; jump wins if both are high. Target bits [1:0] are forced to 0.
- A fire occurs when imem_req && imem_ready.
- States: IDLE, REQ, WAIT, HOLD.
  - imem_req = (state==REQ).
  - instr_valid = (state==HOLD).
- IDLE: next cycle goes to REQ.
- REQ: imem_addr=pc.
  - Fire with no redirect -> WAIT.
  - Fire with redirect -> pc<=target, drop<=1, WAIT.
  - No fire with redirect -> pc<=target, stay REQ. The address may change while unaccepted only on redirect.
- WAIT:
  - rvalid, drop=0, no redirect -> instr<=imem_rdata, HOLD.
  - rvalid and (drop or redirect) -> discard data, drop<=0, go to REQ. On redirect, also pc<=target.
  - No rvalid with redirect -> pc<=target, drop<=1, stay WAIT.
- HOLD: instr, op and pc are stable while instr_ready is low.
  - Redirect -> pc<=target, go to REQ. The held instruction is dropped even if instr_ready is high.
  - instr_ready with no redirect -> pc<=pc+4, go to REQ.
  - Otherwise stay in HOLD.
- Latency: with imem_ready=1 and rvalid one cycle after accept, REQ->WAIT->HOLD gives instr_valid 2 cycles after the request cycle. Best-case throughput is 1 instruction per 3 cycles.
- PC wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000 with no error.
- Exactly one request is outstanding at any time; imem_req is never high in WAIT or HOLD.
- Assertions: no imem_rvalid in IDLE or REQ, and no X on instr_valid after reset.

Decomposition:
- Shared header/package (common.svh): u1/u6/u32 typedefs; fetch state enum (IDLE, REQ, WAIT, HOLD); OP_FIELD_HI/LO constants (31/26); `RESET_PC_DEFAULT.
- The decoder's op constants stay in the same shared header.
- One natural sub-module, `pc_next`: combinational next-PC select (hold, +4, branch, jump, with alignment). All state stays in fetch_unit.

Test Plan:
1. Reset then run with imem_ready=1 and rvalid one cycle later, rdata = {6'h23, 26'h0} (LW), instr_ready=1. Expect fetches at 0x0, 0x4, 0x8; instr_valid every 3rd cycle; op=6'h23; pc_plus4=pc+4.
2. Hold instr_ready=0 for 5 cycles in HOLD at pc=0x8. Expect instr, op, pc stable; imem_req=0. Then raise instr_ready: next request to 0xC.
3. Assert redirect_br with br_target=0x40 during WAIT, then rvalid arrives. Expect data discarded, instr_valid stays 0, next request at 0x40.
4. Assert redirect_j (j_target=0x100) and redirect_br (br_target=0x200) together in HOLD with instr_ready=1. Expect the held instruction dropped and next imem_addr=0x100.
5. Hold imem_ready=0 for 3 cycles in REQ, and redirect to 0x83 in the second cycle. Expect imem_addr changes to 0x80 and stays until accepted; the returned word is presented with pc=0x80.
6. Set RESET_PC=32'hFFFF_FFFC, fetch one instruction and accept it. Expect pc_plus4=0 and next request at 0x0. Pulse reset while in WAIT: expect IDLE, pc=RESET_PC, and a stale rvalid ignored.
